count_capture_ctrl: RTL

Sequencer for the free-running sample counter and its 16-entry capture ring. Starts and stops a capture run, and flags the terminal count. When the run ends, it streams the captured values out oldest-first over a valid/ready handshake. Sits between the test-control socket interface (start/stop commands) and the counter/capture-memory datapath.

---
 rtl/count_capture_ctrl_pkg.sv | 31 +++
 rtl/count_capture_ctrl_if.sv | 38 +++
 rtl/count_capture_ctrl_capture_ring.sv | 57 +++++
 rtl/count_capture_ctrl.sv | 134 +++++++++++++
 4 files changed

// File: rtl/count_capture_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : count_capture_pkg
//  Description : Shared types, default sizes and helpers for the count/capture
//                sequencer slice.
//  Revision    : 1.0 - initial release
// ============================================================================
package count_capture_pkg;

    localparam int DEF_CNT_W    = 8;
    localparam int DEF_DEPTH    = 16;
    localparam int DEF_TERM_CNT = 255;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        READ = 2'd2
    } state_e;

    // Flat state codes used by the sequencer register
    localparam logic [1:0] c_ST_IDLE = 2'(IDLE);
    localparam logic [1:0] c_ST_RUN  = 2'(RUN);
    localparam logic [1:0] c_ST_READ = 2'(READ);

    // Pointer width for a ring of the given depth (never below one bit)
    function automatic int addr_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/count_capture_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : count_capture_ctrl_if
//  Description : Command, status and sample-stream bundle between the test
//                control socket (master) and the capture sequencer (slave).
//  Revision    : 1.0 - initial release
// ============================================================================
interface count_capture_ctrl_if
    import count_capture_pkg::*;
#(
    parameter int CNT_W = DEF_CNT_W,
    parameter int DEPTH = DEF_DEPTH
);
    localparam int c_ADDR_W = addr_w(DEPTH);

    logic               start;
    logic               stop;
    logic [CNT_W-1:0]   count;
    logic               busy;
    logic               term_pulse;
    logic               done;
    logic [c_ADDR_W:0]  fill;
    logic               rd_valid;
    logic               rd_ready;
    logic [CNT_W-1:0]   rd_data;

    modport master (
        output start, stop, rd_ready,
        input  count, busy, term_pulse, done, fill, rd_valid, rd_data
    );

    modport slave (
        input  start, stop, rd_ready,
        output count, busy, term_pulse, done, fill, rd_valid, rd_data
    );

endinterface
`default_nettype wire

// File: rtl/count_capture_ctrl_capture_ring.sv
`default_nettype none
// ============================================================================
//  Module      : capture_ring
//  Description : DEPTH x CNT_W sample ring with wrapping write pointer,
//                saturating fill count and a combinational read port.
//                Contents are intentionally not cleared by reset.
//  Revision    : 1.0 - initial release
// ============================================================================
module capture_ring
    import count_capture_pkg::*;
#(
    parameter int CNT_W = DEF_CNT_W,
    parameter int DEPTH = DEF_DEPTH
) (
    input  wire logic                        clk,
    input  wire logic                        rst,
    input  wire logic                        i_clear,
    input  wire logic                        i_wr_en,
    input  wire logic [CNT_W-1:0]            i_wr_data,
    input  wire logic [addr_w(DEPTH)-1:0]    i_rd_ptr,
    output logic      [CNT_W-1:0]            o_rd_data,
    output logic      [addr_w(DEPTH)-1:0]    o_wr_ptr,
    output logic      [addr_w(DEPTH):0]      o_fill
);
    localparam int                c_ADDR_W = addr_w(DEPTH);
    localparam logic [c_ADDR_W:0] c_FULL   = (c_ADDR_W+1)'(DEPTH);

    logic [CNT_W-1:0]    r_mem [DEPTH];
    logic [c_ADDR_W-1:0] r_wr_ptr;
    logic [c_ADDR_W:0]   r_fill;

    // Sample storage: one write per RUN cycle, no reset on the array
    always_ff @(posedge clk) begin
        if (i_wr_en) begin
            r_mem[r_wr_ptr] <= i_wr_data;
        end
    end

    // Write pointer wraps; fill counts valid entries and stops at DEPTH
    always_ff @(posedge clk) begin
        if (rst || i_clear) begin
            r_wr_ptr <= '0;
            r_fill   <= '0;
        end else if (i_wr_en) begin
            r_wr_ptr <= r_wr_ptr + c_ADDR_W'(1);
            if (r_fill != c_FULL) begin
                r_fill <= r_fill + (c_ADDR_W+1)'(1);
            end
        end
    end

    assign o_rd_data = r_mem[i_rd_ptr];
    assign o_wr_ptr  = r_wr_ptr;
    assign o_fill    = r_fill;

endmodule
`default_nettype wire

// File: rtl/count_capture_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : count_capture_ctrl
//  Description : Capture-run sequencer. IDLE -> RUN on start, samples the
//                free-running counter into the ring every RUN cycle, flags
//                the terminal count, then streams the ring oldest-first over
//                a valid/ready handshake in READ.
//                Build option CCC_AUTO_STOP_EN: reaching TERM_CNT in RUN
//                ends the run as if stop had been asserted.
//  Revision    : 1.0 - initial release
// ============================================================================
module count_capture_ctrl
    import count_capture_pkg::*;
#(
    parameter int CNT_W    = DEF_CNT_W,
    parameter int DEPTH    = DEF_DEPTH,
    parameter int TERM_CNT = DEF_TERM_CNT
) (
    input  wire logic             clk,
    input  wire logic             rst,
    count_capture_ctrl_if.slave   bus
);
    localparam int                c_ADDR_W = addr_w(DEPTH);
    localparam logic [c_ADDR_W:0] c_FULL   = (c_ADDR_W+1)'(DEPTH);
    localparam logic [CNT_W-1:0]  c_TERM   = CNT_W'(TERM_CNT);

    logic [1:0]          r_state;
    logic [CNT_W-1:0]    r_count;
    logic [c_ADDR_W-1:0] r_rd_ptr;
    logic [c_ADDR_W-1:0] r_rd_idx;
    logic                r_done;
    logic [CNT_W-1:0]    r_rd_hold;

    logic [c_ADDR_W-1:0] w_wr_ptr;
    logic [c_ADDR_W:0]   w_fill;
    logic [CNT_W-1:0]    w_mem_data;
    logic                w_idle;
    logic                w_run;
    logic                w_read;
    logic                w_term;
    logic                w_end_run;
    logic                w_hs;
    logic                w_last;
    logic                w_full_next;
    logic                w_clear;

    assign w_idle  = (r_state == c_ST_IDLE);
    assign w_run   = (r_state == c_ST_RUN);
    assign w_read  = (r_state == c_ST_READ);
    assign w_term  = w_run && (r_count == c_TERM);
    assign w_clear = w_idle && bus.start;

`ifdef CCC_AUTO_STOP_EN
    assign w_end_run = bus.stop || w_term;
`else
    assign w_end_run = bus.stop;
`endif

    assign w_hs        = w_read && bus.rd_ready;
    assign w_last      = ({1'b0, r_rd_idx} == (w_fill - (c_ADDR_W+1)'(1)));
    // Ring will be full after this cycle's write: oldest entry sits at the
    // next write position, otherwise it is entry 0
    assign w_full_next = (w_fill >= (c_FULL - (c_ADDR_W+1)'(1)));

    capture_ring #(
        .CNT_W (CNT_W),
        .DEPTH (DEPTH)
    ) u_ring (
        .clk       (clk),
        .rst       (rst),
        .i_clear   (w_clear),
        .i_wr_en   (w_run),
        .i_wr_data (r_count),
        .i_rd_ptr  (r_rd_ptr),
        .o_rd_data (w_mem_data),
        .o_wr_ptr  (w_wr_ptr),
        .o_fill    (w_fill)
    );

    // Sequencer: state, counter, read-out pointers and done pulse
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= c_ST_IDLE;
            r_count   <= '0;
            r_rd_ptr  <= '0;
            r_rd_idx  <= '0;
            r_done    <= 1'b0;
            r_rd_hold <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                c_ST_IDLE: begin
                    if (bus.start) begin
                        r_state <= c_ST_RUN;
                        r_count <= '0;
                    end
                end
                c_ST_RUN: begin
                    r_count <= r_count + CNT_W'(1);
                    if (w_end_run) begin
                        r_state  <= c_ST_READ;
                        r_rd_ptr <= w_full_next ? (w_wr_ptr + c_ADDR_W'(1)) : '0;
                        r_rd_idx <= '0;
                    end
                end
                c_ST_READ: begin
                    if (w_hs) begin
                        r_rd_ptr  <= r_rd_ptr + c_ADDR_W'(1);
                        r_rd_idx  <= r_rd_idx + c_ADDR_W'(1);
                        r_rd_hold <= w_mem_data;
                        if (w_last) begin
                            r_state <= c_ST_IDLE;
                            r_done  <= 1'b1;
                        end
                    end
                end
                default: begin
                    r_state <= c_ST_IDLE;
                end
            endcase
        end
    end

    // Outside READ the stream keeps showing the last accepted sample
    assign bus.rd_data    = w_read ? w_mem_data : r_rd_hold;
    assign bus.rd_valid   = w_read;
    assign bus.count      = r_count;
    assign bus.busy       = !w_idle;
    assign bus.term_pulse = w_term;
    assign bus.done       = r_done;
    assign bus.fill       = w_fill;

endmodule
`default_nettype wire
